// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: op codes, FSM states, muldiv modes
// and flag bit positions.
package seq_alu_pkg;

  localparam logic [3:0] OP_NOT = 4'd0;
  localparam logic [3:0] OP_AND = 4'd1;
  localparam logic [3:0] OP_OR  = 4'd2;
  localparam logic [3:0] OP_XOR = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_SUB = 4'd5;
  localparam logic [3:0] OP_LT  = 4'd6;
  localparam logic [3:0] OP_EQ  = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_DIV = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    BUSY = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic {
    MD_MUL = 1'b0,
    MD_DIV = 1'b1
  } md_mode_t;

  localparam int FLAGS_W    = 4;
  localparam int FLAG_CARRY = 0;
  localparam int FLAG_OVF   = 1;
  localparam int FLAG_DZ    = 2;
  localparam int FLAG_ILL   = 3;

  // Divide by zero resolves in a single cycle, so only a non-zero divisor iterates.
  function automatic logic is_iterative(input logic [3:0] op, input logic b_nonzero);
    return (op == OP_MUL) || ((op == OP_DIV) && b_nonzero);
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Request/response bundle between the issue stage, the ALU and writeback.
interface seq_alu_if import seq_alu_pkg::*; #(parameter int WIDTH = 16);

  logic               in_valid;
  logic               in_ready;
  logic [3:0]         op;
  logic [WIDTH-1:0]   operand_a;
  logic [WIDTH-1:0]   operand_b;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   result;
  logic [WIDTH-1:0]   result_hi;
  logic [FLAGS_W-1:0] flags;
  logic               flags_z;

  modport master (
    output in_valid, op, operand_a, operand_b, out_ready,
    input  in_ready, out_valid, result, result_hi, flags, flags_z
  );

  modport slave (
    input  in_valid, op, operand_a, operand_b, out_ready,
    output in_ready, out_valid, result, result_hi, flags, flags_z
  );

endinterface

// File: rtl/seq_alu_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider sharing one
// accumulator, one shift register and one iteration counter.
module seq_alu_muldiv import seq_alu_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  md_mode_t         mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(WIDTH);

  // acc: upper product half / partial remainder; sr: multiplier / quotient
  logic [WIDTH-1:0] acc_p0, sr_p0, opnd_p0;
  md_mode_t         mode_p0;
  logic             active;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH:0]   mul_sum, div_shift, div_trial;
  logic [WIDTH-1:0] acc_nxt, sr_nxt;

  always_comb begin
    mul_sum   = {1'b0, acc_p0} + (sr_p0[0] ? {1'b0, opnd_p0} : '0);
    div_shift = {acc_p0, sr_p0[WIDTH-1]};
    div_trial = div_shift - {1'b0, opnd_p0};
    acc_nxt   = mul_sum[WIDTH:1];
    sr_nxt    = {mul_sum[0], sr_p0[WIDTH-1:1]};
    if (mode_p0 == MD_DIV) begin
      // A set top bit means the trial subtraction went negative: restore.
      if (div_trial[WIDTH]) begin
        acc_nxt = div_shift[WIDTH-1:0];
        sr_nxt  = {sr_p0[WIDTH-2:0], 1'b0};
      end else begin
        acc_nxt = div_trial[WIDTH-1:0];
        sr_nxt  = {sr_p0[WIDTH-2:0], 1'b1};
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      active <= 1'b0;
      cnt    <= '0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= '0;
    end else if (active) begin
      cnt <= cnt + 1'b1;
      if (cnt == CNT_LAST) active <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (start) begin
      mode_p0 <= mode;
      acc_p0  <= '0;
      sr_p0   <= (mode == MD_MUL) ? b : a;
      opnd_p0 <= (mode == MD_MUL) ? a : b;
    end else if (active) begin
      acc_p0 <= acc_nxt;
      sr_p0  <= sr_nxt;
    end
  end

  assign done = !active && (cnt == CNT_DONE);
  assign lo   = sr_p0;
  assign hi   = acc_p0;

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: single-cycle logic/arithmetic ops plus iterative MUL/DIV,
// with registered result, high half/remainder and status flags.
module seq_alu import seq_alu_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic    clock,
  input  logic    reset,
  seq_alu_if.slave bus
);

  state_t state_q, state_d;

  logic             accept, start, load_alu, load_md;
  md_mode_t         md_mode;
  logic             md_done;
  logic [WIDTH-1:0] md_lo, md_hi;

  logic [3:0]       op_p0;
  logic [WIDTH-1:0] a_p0, b_p0;

  logic [WIDTH:0]          add_full, sub_full;
  logic signed [WIDTH-1:0] sa, sb, s_sum, s_diff;
  logic [WIDTH-1:0]        alu_res, alu_hi;
  logic [FLAGS_W-1:0]      alu_flags;

  logic [WIDTH-1:0]   res_p1, res_hi_p1;
  logic [FLAGS_W-1:0] flags_p1;
  logic               flags_z_p1, vld_p1;

  function automatic logic add_ovf(input logic signed [WIDTH-1:0] x,
                                   input logic signed [WIDTH-1:0] y,
                                   input logic signed [WIDTH-1:0] s);
    return (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
  endfunction

  function automatic logic sub_ovf(input logic signed [WIDTH-1:0] x,
                                   input logic signed [WIDTH-1:0] y,
                                   input logic signed [WIDTH-1:0] d);
    return (x[WIDTH-1] != y[WIDTH-1]) && (d[WIDTH-1] != x[WIDTH-1]);
  endfunction

  assign bus.in_ready = (state_q == IDLE) && !reset;
  assign accept       = bus.in_valid && bus.in_ready;
  assign md_mode      = (bus.op == OP_DIV) ? MD_DIV : MD_MUL;
  assign start        = accept && is_iterative(bus.op, |bus.operand_b);

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    load_alu = 1'b0;
    load_md  = 1'b0;
    unique case (state_q)
      IDLE: if (accept) state_d = start ? BUSY : EXEC;
      EXEC: begin
        state_d  = DONE;
        load_alu = 1'b1;
      end
      BUSY: if (md_done) begin
        state_d = DONE;
        load_md = 1'b1;
      end
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage p0: request captured on acceptance
  always_ff @(posedge clock) begin
    if (accept) begin
      op_p0 <= bus.op;
      a_p0  <= bus.operand_a;
      b_p0  <= bus.operand_b;
    end
  end

  seq_alu_muldiv #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_muldiv (
    .clock (clock),
    .reset (reset),
    .start (start),
    .mode  (md_mode),
    .a     (bus.operand_a),
    .b     (bus.operand_b),
    .done  (md_done),
    .lo    (md_lo),
    .hi    (md_hi)
  );

  assign add_full = {1'b0, a_p0} + {1'b0, b_p0};
  assign sub_full = {1'b0, a_p0} - {1'b0, b_p0};
  assign sa       = $signed(a_p0);
  assign sb       = $signed(b_p0);
  assign s_sum    = $signed(add_full[WIDTH-1:0]);
  assign s_diff   = $signed(sub_full[WIDTH-1:0]);

  always_comb begin
    alu_res   = '0;
    alu_hi    = '0;
    alu_flags = '0;
    case (op_p0)
      OP_NOT: alu_res = ~a_p0;
      OP_AND: alu_res = a_p0 & b_p0;
      OP_OR:  alu_res = a_p0 | b_p0;
      OP_XOR: alu_res = a_p0 ^ b_p0;
      OP_ADD: begin
        alu_res              = add_full[WIDTH-1:0];
        alu_flags[FLAG_CARRY] = add_full[WIDTH];
        alu_flags[FLAG_OVF]   = add_ovf(sa, sb, s_sum);
      end
      OP_SUB: begin
        alu_res              = sub_full[WIDTH-1:0];
        alu_flags[FLAG_CARRY] = sub_full[WIDTH];
        alu_flags[FLAG_OVF]   = sub_ovf(sa, sb, s_diff);
      end
      OP_LT:  alu_res[0] = (a_p0 < b_p0);
      OP_EQ:  alu_res[0] = (a_p0 == b_p0);
      // MUL always iterates; DIV only lands here with a zero divisor.
      OP_MUL: alu_res = '0;
      OP_DIV: begin
        alu_res           = '1;
        alu_hi            = a_p0;
        alu_flags[FLAG_DZ] = 1'b1;
      end
      default: alu_flags[FLAG_ILL] = 1'b1;
    endcase
  end

  // Stage p1: registered result held until the consumer takes it
  always_ff @(posedge clock) begin
    if (reset) begin
      res_p1     <= '0;
      res_hi_p1  <= '0;
      flags_p1   <= '0;
      flags_z_p1 <= 1'b0;
    end else if (load_alu) begin
      res_p1     <= alu_res;
      res_hi_p1  <= alu_hi;
      flags_p1   <= alu_flags;
      flags_z_p1 <= (alu_res == '0);
    end else if (load_md) begin
      res_p1     <= md_lo;
      res_hi_p1  <= md_hi;
      flags_p1   <= '0;
      flags_z_p1 <= (md_lo == '0);
    end
  end

  assign vld_p1        = (state_q == DONE);
  assign bus.out_valid = vld_p1;
  assign bus.result    = res_p1;
  assign bus.result_hi = res_hi_p1;
  assign bus.flags     = flags_p1;
  assign bus.flags_z   = flags_z_p1;

endmodule
